// File: rtl/pkt_queue_head_updater.sv
// Packet-queue head updater: commits software head-pointer writes to the
// head table and queues descriptor-only metadata toward the queue manager,
// merging repeated updates to a queue that is still pending.

package pkt_queue_head_updater_pkg;
  localparam int unsigned RB_AWIDTH          = 16;
  localparam int unsigned PKT_QUEUE_ID_WIDTH = 12;
  localparam int unsigned DSC_QUEUE_ID_WIDTH = 12;
  localparam int unsigned PKT_Q_STATE_WIDTH  = 16;
  localparam int unsigned PKT_SIZE_WIDTH     = 16;

  typedef logic [PKT_QUEUE_ID_WIDTH-1:0] pkt_queue_id;

  typedef struct packed {
    logic [PKT_QUEUE_ID_WIDTH-1:0] pkt_queue_id;
    logic [DSC_QUEUE_ID_WIDTH-1:0] dsc_queue_id;
    logic [PKT_Q_STATE_WIDTH-1:0]  pkt_q_state;
    logic [PKT_SIZE_WIDTH-1:0]     size;
    logic                          descriptor_only;
    logic                          drop_data;
    logic                          drop_meta;
    logic                          needs_dsc;
  } pkt_meta_with_queues_t;
endpackage

module pkt_queue_head_updater
  import pkt_queue_head_updater_pkg::*;
#(
  parameter int unsigned NB_QUEUES     = 512,
  parameter int unsigned PENDING_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  pkt_queue_id                  in_queue_id,
  input  logic [RB_AWIDTH-1:0]         in_head,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         head_wr_en,
  output logic [$clog2(NB_QUEUES)-1:0] head_wr_addr,
  output logic [RB_AWIDTH-1:0]         head_wr_data,
  output pkt_meta_with_queues_t        out_meta_data,
  output logic                         out_meta_valid,
  input  logic                         out_meta_ready,
  input  logic [RB_AWIDTH:0]           rb_size,
  output logic [31:0]                  coalesced_cnt,
  output logic [31:0]                  bad_head_cnt
);

  localparam int unsigned QUEUE_ID_WIDTH = $clog2(NB_QUEUES);
  localparam int unsigned CW             = $clog2(PENDING_DEPTH) + 1;

  // Pending entries only carry the queue id: the head value itself is
  // committed to the table on accept, so a coalesced update has nothing
  // further to record in the entry.
  pkt_queue_id    ids   [PENDING_DEPTH];
  pkt_queue_id    ids_n [PENDING_DEPTH];
  logic [CW-1:0]  count, count_n, tail;
  logic           pop, accept, head_ok, match, append;

  // Next buffer contents: shift on pop, then either merge or append.
  always_comb begin
    pop     = (count != '0) && out_meta_ready;
    accept  = in_valid && in_ready;
    head_ok = ({1'b0, in_head} < rb_size);
    match   = 1'b0;
    for (int unsigned i = 0; i < PENDING_DEPTH; i++) begin
      // Entry 0 leaving this cycle cannot absorb the update.
      if ((i < 32'(count)) && (ids[i] == in_queue_id) && !((i == 0) && pop))
        match = 1'b1;
    end
    append = accept && head_ok && !match;
    for (int unsigned i = 0; i < PENDING_DEPTH - 1; i++)
      ids_n[i] = pop ? ids[i+1] : ids[i];
    ids_n[PENDING_DEPTH-1] = ids[PENDING_DEPTH-1];
    tail = count - CW'(pop);
    if (append)
      ids_n[tail[CW-2:0]] = in_queue_id;
    count_n = count - CW'(pop) + CW'(append);
  end

  // Buffer state and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      in_ready <= 1'b0;
      for (int unsigned i = 0; i < PENDING_DEPTH; i++)
        ids[i] <= '0;
    end else begin
      count    <= count_n;
      in_ready <= (count_n != CW'(PENDING_DEPTH));
      for (int unsigned i = 0; i < PENDING_DEPTH; i++)
        ids[i] <= ids_n[i];
    end
  end

  // One-cycle head table write for every in-range update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_wr_en   <= 1'b0;
      head_wr_addr <= '0;
      head_wr_data <= '0;
    end else begin
      head_wr_en <= accept && head_ok;
      if (accept && head_ok) begin
        head_wr_addr <= in_queue_id[PKT_QUEUE_ID_WIDTH-1 -: QUEUE_ID_WIDTH];
        head_wr_data <= in_head;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coalesced_cnt <= '0;
      bad_head_cnt  <= '0;
    end else begin
      if (accept && head_ok && match && (coalesced_cnt != '1))
        coalesced_cnt <= coalesced_cnt + 32'd1;
      if (accept && !head_ok && (bad_head_cnt != '1))
        bad_head_cnt <= bad_head_cnt + 32'd1;
    end
  end

  // Head of the buffer presented as descriptor-only metadata.
  always_comb begin
    out_meta_valid = (count != '0);
    out_meta_data  = '0;
    if (out_meta_valid) begin
      out_meta_data.pkt_queue_id    = ids[0];
      out_meta_data.descriptor_only = 1'b1;
      out_meta_data.drop_data       = 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_queue_head_updater.sv
// Directed self-checking bench for pkt_queue_head_updater.
module tb_pkt_queue_head_updater;
  import pkt_queue_head_updater_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  pkt_queue_id           in_queue_id;
  logic [RB_AWIDTH-1:0]  in_head;
  logic                  in_valid;
  logic                  in_ready;
  logic                  head_wr_en;
  logic [8:0]            head_wr_addr;
  logic [RB_AWIDTH-1:0]  head_wr_data;
  pkt_meta_with_queues_t out_meta_data;
  logic                  out_meta_valid;
  logic                  out_meta_ready;
  logic [RB_AWIDTH:0]    rb_size;
  logic [31:0]           coalesced_cnt;
  logic [31:0]           bad_head_cnt;

  int checks = 0;
  int errors = 0;

  pkt_queue_head_updater #(.NB_QUEUES(512), .PENDING_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_queue_id(in_queue_id), .in_head(in_head), .in_valid(in_valid), .in_ready(in_ready),
    .head_wr_en(head_wr_en), .head_wr_addr(head_wr_addr), .head_wr_data(head_wr_data),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
    .rb_size(rb_size), .coalesced_cnt(coalesced_cnt), .bad_head_cnt(bad_head_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_meta_with_queues_t mk_meta(input pkt_queue_id id);
    pkt_meta_with_queues_t m;
    m = '0;
    m.pkt_queue_id    = id;
    m.descriptor_only = 1'b1;
    m.drop_data       = 1'b1;
    return m;
  endfunction

  task automatic write(input pkt_queue_id q, input logic [RB_AWIDTH-1:0] h);
    in_valid    = 1'b1;
    in_queue_id = q;
    in_head     = h;
    step();
    in_valid    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_queue_id = '0; in_head = '0;
    out_meta_ready = 1'b0; rb_size = 17'd1024;
    step(); step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_head_wr_en", 64'(head_wr_en), 64'd0);
    check("rst_meta_valid", 64'(out_meta_valid), 64'd0);
    check("rst_meta_data", 64'(out_meta_data), 64'd0);
    check("rst_coalesced", 64'(coalesced_cnt), 64'd0);
    check("rst_bad", 64'(bad_head_cnt), 64'd0);
    rst_n = 1'b1;
    step();
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // 1: single update, output ready
    out_meta_ready = 1'b1;
    write(12'd5, 16'd10);
    check("t1_wr_en", 64'(head_wr_en), 64'd1);
    check("t1_wr_addr", 64'(head_wr_addr), 64'd0);
    check("t1_wr_data", 64'(head_wr_data), 64'd10);
    check("t1_meta_valid", 64'(out_meta_valid), 64'd1);
    check("t1_meta", 64'(out_meta_data), 64'(mk_meta(12'd5)));
    step();
    check("t1_wr_pulse", 64'(head_wr_en), 64'd0);
    check("t1_meta_gone", 64'(out_meta_valid), 64'd0);

    // 2: coalescing under back-pressure
    out_meta_ready = 1'b0;
    write(12'd3, 16'd4);
    write(12'd3, 16'd9);
    write(12'd7, 16'd2);
    check("t2_coalesced", 64'(coalesced_cnt), 64'd1);
    check("t2_wr_data", 64'(head_wr_data), 64'd2);
    check("t2_first", 64'(out_meta_data), 64'(mk_meta(12'd3)));
    step();
    check("t2_hold", 64'(out_meta_data), 64'(mk_meta(12'd3)));
    out_meta_ready = 1'b1;
    step();
    check("t2_second", 64'(out_meta_data), 64'(mk_meta(12'd7)));
    step();
    check("t2_empty", 64'(out_meta_valid), 64'd0);

    // 3: fill the buffer, hold the 9th update, release one slot
    out_meta_ready = 1'b0;
    for (int i = 0; i < 8; i++) write(pkt_queue_id'(16 + i), 16'(i));
    check("t3_full", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_queue_id = 12'd100; in_head = 16'd1;
    step();
    check("t3_held", 64'(in_ready), 64'd0);
    check("t3_no_coal", 64'(coalesced_cnt), 64'd1);
    out_meta_ready = 1'b1;
    step();
    check("t3_ready_back", 64'(in_ready), 64'd1);
    check("t3_after_pop", 64'(out_meta_data), 64'(mk_meta(12'd17)));
    out_meta_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("t3_full_again", 64'(in_ready), 64'd0);
    out_meta_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t3_drain_valid", 64'(out_meta_valid), 64'd1);
      check("t3_drain_id", 64'(out_meta_data),
            64'(mk_meta((i < 7) ? pkt_queue_id'(17 + i) : 12'd100)));
      step();
    end
    check("t3_drained", 64'(out_meta_valid), 64'd0);

    // 4: head range check
    write(12'hABC, 16'd1024);
    check("t4_no_wr", 64'(head_wr_en), 64'd0);
    check("t4_no_meta", 64'(out_meta_valid), 64'd0);
    check("t4_bad", 64'(bad_head_cnt), 64'd1);
    write(12'hABC, 16'd1023);
    check("t4_wr", 64'(head_wr_en), 64'd1);
    check("t4_addr", 64'(head_wr_addr), 64'h157);
    check("t4_data", 64'(head_wr_data), 64'd1023);
    check("t4_meta", 64'(out_meta_data), 64'(mk_meta(12'hABC)));
    check("t4_bad_same", 64'(bad_head_cnt), 64'd1);
    step();

    // 5: same-queue update while entry 0 is leaving
    out_meta_ready = 1'b0;
    write(12'd4, 16'd3);
    out_meta_ready = 1'b1;
    write(12'd4, 16'd6);
    check("t5_second_meta", 64'(out_meta_data), 64'(mk_meta(12'd4)));
    check("t5_coal_same", 64'(coalesced_cnt), 64'd1);
    check("t5_wr_data", 64'(head_wr_data), 64'd6);
    step();
    check("t5_empty", 64'(out_meta_valid), 64'd0);

    // 6: asynchronous reset with pending entries
    out_meta_ready = 1'b0;
    write(12'd1, 16'd1);
    write(12'd2, 16'd1);
    write(12'd3, 16'd1);
    check("t6_pending", 64'(out_meta_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_meta_valid), 64'd0);
    check("t6_rst_data", 64'(out_meta_data), 64'd0);
    check("t6_rst_coal", 64'(coalesced_cnt), 64'd0);
    check("t6_rst_bad", 64'(bad_head_cnt), 64'd0);
    check("t6_rst_ready", 64'(in_ready), 64'd0);
    step();
    rst_n = 1'b1;
    out_meta_ready = 1'b1;
    step();
    check("t6_ready", 64'(in_ready), 64'd1);
    check("t6_no_stale", 64'(out_meta_valid), 64'd0);
    step();
    check("t6_no_stale2", 64'(out_meta_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
